// File: rtl/rx_word_assembler_if.sv
// Byte-in / word-out bundle between the UART receiver, the word assembler and the debug unit.
// Signal prefixes follow the assembler's view: i_ = into the assembler, o_ = out of it.
interface rx_word_assembler_if #(
   parameter int WORD_WIDTH = 32,
   parameter int RX_WIDTH   = 8
);
   localparam int CNT_W = $clog2(WORD_WIDTH / RX_WIDTH) + 1;

   logic                  i_rx_done;
   logic [RX_WIDTH-1:0]   i_rx_data;
   logic                  i_clear;
   logic                  i_word_ack;
   logic [WORD_WIDTH-1:0] o_word;
   logic                  o_word_valid;
   logic [CNT_W-1:0]      o_byte_count;
   logic                  o_overrun;

   modport master (
      output i_rx_done, i_rx_data, i_clear, i_word_ack,
      input  o_word, o_word_valid, o_byte_count, o_overrun
   );

   modport slave (
      input  i_rx_done, i_rx_data, i_clear, i_word_ack,
      output o_word, o_word_valid, o_byte_count, o_overrun
   );
endinterface

// File: rtl/rx_word_assembler.sv
// Packs UART bytes little-endian into words and hands each finished word to the debug unit
// over a valid/ack handshake; bytes arriving while a finished word is unacked are dropped.
module rx_word_assembler #(
   parameter int  WORD_WIDTH     = 32,
   parameter int  RX_WIDTH       = 8,
   localparam int BYTES_PER_WORD = WORD_WIDTH / RX_WIDTH,
   localparam int CNT_W          = $clog2(BYTES_PER_WORD) + 1
) (
   input  logic           i_clk,
   input  logic           i_reset,
   rx_word_assembler_if.slave bus
);
   typedef enum logic {
      S_COLLECT = 1'b0,
      S_FULL    = 1'b1
   } state_t;

   state_t                r_state;
   logic [WORD_WIDTH-1:0] r_word;
   logic                  r_word_valid;
   logic [CNT_W-1:0]      r_byte_count;
   logic                  r_overrun;

   logic [WORD_WIDTH-1:0] w_word_insert;
   logic [WORD_WIDTH-1:0] w_word_restart;
   logic                  w_last_byte;

   // Lane gi takes the incoming byte when it is the next one to fill; on a
   // retire-and-restart only lane 0 carries data so stale lanes come up zero.
   genvar gi;
   generate
      for (gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
         logic w_lane_hit;
         assign w_lane_hit = (r_byte_count == CNT_W'(gi));
         assign w_word_insert[gi*RX_WIDTH +: RX_WIDTH] =
            w_lane_hit ? bus.i_rx_data : r_word[gi*RX_WIDTH +: RX_WIDTH];
         if (gi == 0) begin : g_first
            assign w_word_restart[gi*RX_WIDTH +: RX_WIDTH] = bus.i_rx_data;
         end else begin : g_rest
            assign w_word_restart[gi*RX_WIDTH +: RX_WIDTH] = '0;
         end
      end
   endgenerate

   assign w_last_byte = (r_byte_count == CNT_W'(BYTES_PER_WORD - 1));

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state      <= S_COLLECT;
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_byte_count <= '0;
         r_overrun    <= 1'b0;
      end else if (bus.i_clear) begin
         r_state      <= S_COLLECT;
         r_word       <= '0;
         r_word_valid <= 1'b0;
         r_byte_count <= '0;
         r_overrun    <= 1'b0;
      end else begin
         case (r_state)
            S_COLLECT: begin
               if (bus.i_rx_done) begin
                  r_word       <= w_word_insert;
                  r_byte_count <= r_byte_count + CNT_W'(1);
                  if (w_last_byte) begin
                     r_state      <= S_FULL;
                     r_word_valid <= 1'b1;
                  end
               end
            end
            S_FULL: begin
               if (bus.i_word_ack) begin
                  r_state      <= S_COLLECT;
                  r_word_valid <= 1'b0;
                  // A byte coinciding with the ack starts the next word instead of being lost.
                  if (bus.i_rx_done) begin
                     r_word       <= w_word_restart;
                     r_byte_count <= CNT_W'(1);
                  end else begin
                     r_word       <= '0;
                     r_byte_count <= '0;
                  end
               end else if (bus.i_rx_done) begin
                  r_overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= S_COLLECT;
            end
         endcase
      end
   end

   assign bus.o_word       = r_word;
   assign bus.o_word_valid = r_word_valid;
   assign bus.o_byte_count = r_byte_count;
   assign bus.o_overrun    = r_overrun;
endmodule

// File: tb/tb_rx_word_assembler.sv
// Self-checking bench for rx_word_assembler: directed table, hand-written corner sequences,
// and random traffic compared against a byte-queue reference model.
module tb_rx_word_assembler;
   localparam int BPW = 4;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;

   rx_word_assembler_if #(.WORD_WIDTH(32), .RX_WIDTH(8)) bus ();

   rx_word_assembler #(.WORD_WIDTH(32), .RX_WIDTH(8)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rx;
      logic [7:0]  d;
      logic        clr;
      logic        ack;
      logic [31:0] w;
      logic        v;
      logic [2:0]  c;
      logic        o;
   } vec_t;

   vec_t vecs[$];

   // Reference model: the bytes held so far, in arrival order, plus the sticky drop flag.
   logic [7:0] m_bytes[$];
   logic       m_ovr;

   task automatic add_vec(input logic rx, input logic [7:0] d, input logic clr, input logic ack,
                          input logic [31:0] w, input logic v, input logic [2:0] c, input logic o);
      vec_t t;
      t.rx = rx; t.d = d; t.clr = clr; t.ack = ack;
      t.w = w; t.v = v; t.c = c; t.o = o;
      vecs.push_back(t);
   endtask

   task automatic apply(input logic rx, input logic [7:0] d, input logic clr, input logic ack);
      bus.i_rx_done  = rx;
      bus.i_rx_data  = d;
      bus.i_clear    = clr;
      bus.i_word_ack = ack;
      @(posedge clk);
      #1;
      bus.i_rx_done  = 1'b0;
      bus.i_clear    = 1'b0;
      bus.i_word_ack = 1'b0;
   endtask

   // Word lanes beyond the byte count are don't-care unless whole_word is set.
   task automatic chk(input string name, input logic [31:0] exp_w, input logic exp_v,
                      input logic [2:0] exp_c, input logic exp_o, input bit whole_word);
      logic [31:0] mask;
      mask = whole_word ? 32'hFFFF_FFFF : 32'h0;
      for (int i = 0; i < BPW; i++) begin
         if (i < int'(exp_c)) mask[i*8 +: 8] = 8'hFF;
      end
      $display("[TB] %s: cnt=%0d valid=%0b word=%08h ovr=%0b", name, bus.o_byte_count,
               bus.o_word_valid, bus.o_word, bus.o_overrun);
      n_tests++;
      if (bus.o_byte_count !== exp_c) begin
         n_fail++;
         $display("FAIL %s byte_count: got %0d expected %0d", name, bus.o_byte_count, exp_c);
      end
      n_tests++;
      if (bus.o_word_valid !== exp_v) begin
         n_fail++;
         $display("FAIL %s word_valid: got %0b expected %0b", name, bus.o_word_valid, exp_v);
      end
      n_tests++;
      if (bus.o_overrun !== exp_o) begin
         n_fail++;
         $display("FAIL %s overrun: got %0b expected %0b", name, bus.o_overrun, exp_o);
      end
      if (mask != 32'h0) begin
         n_tests++;
         if ((bus.o_word & mask) !== (exp_w & mask)) begin
            n_fail++;
            $display("FAIL %s word: got %08h expected %08h (mask %08h)", name, bus.o_word,
                     exp_w, mask);
         end
      end
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_ovr = 1'b0;
   endtask

   task automatic model_step(input logic rx, input logic [7:0] d, input logic clr,
                             input logic ack);
      if (clr) begin
         model_reset();
      end else if (m_bytes.size() == BPW) begin
         if (ack) begin
            m_bytes.delete();
            if (rx) m_bytes.push_back(d);
         end else if (rx) begin
            m_ovr = 1'b1;
         end
      end else if (rx) begin
         m_bytes.push_back(d);
      end
   endtask

   task automatic model_check(input string name);
      logic [31:0] w;
      w = 32'h0;
      for (int i = 0; i < m_bytes.size(); i++) w[i*8 +: 8] = m_bytes[i];
      chk(name, w, (m_bytes.size() == BPW), 3'(m_bytes.size()), m_ovr, 1'b0);
   endtask

   initial begin
      logic        rx, clr, ack;
      logic [7:0]  d;
      logic [7:0]  gap_bytes[4];
      logic [31:0] exp_w;

      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      bus.i_rx_done = 1'b0; bus.i_rx_data = 8'h00; bus.i_clear = 1'b0; bus.i_word_ack = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_held", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
      rst = 1'b0;
      apply(1'b0, 8'h00, 1'b0, 1'b0);
      chk("reset_released", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);

      // Bytes with 10-cycle gaps
      gap_bytes[0] = 8'h78; gap_bytes[1] = 8'h56; gap_bytes[2] = 8'h34; gap_bytes[3] = 8'h12;
      exp_w = 32'h0;
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, gap_bytes[i], 1'b0, 1'b0);
         exp_w[i*8 +: 8] = gap_bytes[i];
         chk($sformatf("gap_byte%0d", i), exp_w, (i == 3), 3'(i + 1), 1'b0, 1'b0);
         repeat (9) apply(1'b0, 8'h00, 1'b0, 1'b0);
      end
      chk("gap_hold", 32'h12345678, 1'b1, 3'd4, 1'b0, 1'b1);
      apply(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("overrun_drop", 32'h12345678, 1'b1, 3'd4, 1'b1, 1'b1);
      apply(1'b0, 8'h00, 1'b0, 1'b1);
      chk("overrun_ack", 32'h0, 1'b0, 3'd0, 1'b1, 1'b1);
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      chk("overrun_clear", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);

      // Directed per-cycle table, starting from an empty assembler
      add_vec(1, 8'h01, 0, 0, 32'h00000001, 0, 1, 0);
      add_vec(1, 8'h02, 0, 0, 32'h00000201, 0, 2, 0);
      add_vec(1, 8'h03, 0, 0, 32'h00030201, 0, 3, 0);
      add_vec(1, 8'h04, 0, 0, 32'h04030201, 1, 4, 0);
      add_vec(0, 8'h00, 0, 1, 32'h00000000, 0, 0, 0);
      add_vec(0, 8'h00, 0, 1, 32'h00000000, 0, 0, 0);
      add_vec(1, 8'hEF, 0, 1, 32'h000000EF, 0, 1, 0);
      add_vec(1, 8'hBE, 0, 0, 32'h0000BEEF, 0, 2, 0);
      add_vec(1, 8'hAD, 0, 0, 32'h00ADBEEF, 0, 3, 0);
      add_vec(1, 8'hDE, 0, 0, 32'hDEADBEEF, 1, 4, 0);
      add_vec(0, 8'h00, 0, 0, 32'hDEADBEEF, 1, 4, 0);
      add_vec(1, 8'h11, 0, 1, 32'h00000011, 0, 1, 0);
      add_vec(1, 8'h22, 0, 0, 32'h00002211, 0, 2, 0);
      add_vec(1, 8'h33, 0, 0, 32'h00332211, 0, 3, 0);
      add_vec(1, 8'h44, 0, 0, 32'h44332211, 1, 4, 0);
      add_vec(1, 8'h55, 0, 0, 32'h44332211, 1, 4, 1);
      add_vec(0, 8'h00, 0, 0, 32'h44332211, 1, 4, 1);
      add_vec(0, 8'h00, 0, 1, 32'h00000000, 0, 0, 1);
      add_vec(1, 8'hCD, 0, 0, 32'h000000CD, 0, 1, 1);
      add_vec(1, 8'hAB, 0, 0, 32'h0000ABCD, 0, 2, 1);
      add_vec(1, 8'hFF, 1, 0, 32'h00000000, 0, 0, 0);
      add_vec(1, 8'h01, 0, 0, 32'h00000001, 0, 1, 0);
      add_vec(1, 8'h02, 0, 0, 32'h00000201, 0, 2, 0);
      add_vec(1, 8'h03, 0, 0, 32'h00030201, 0, 3, 0);
      add_vec(1, 8'h04, 0, 0, 32'h04030201, 1, 4, 0);
      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i].rx, vecs[i].d, vecs[i].clr, vecs[i].ack);
         chk($sformatf("vec%0d", i), vecs[i].w, vecs[i].v, vecs[i].c, vecs[i].o,
             (vecs[i].c == 3'd0));
      end

      // Asynchronous reset between edges, mid-word
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      apply(1'b1, 8'hA1, 1'b0, 1'b0);
      apply(1'b1, 8'hA2, 1'b0, 1'b0);
      apply(1'b1, 8'hA3, 1'b0, 1'b0);
      chk("pre_async", 32'h00A3A2A1, 1'b0, 3'd3, 1'b0, 1'b0);
      #3;
      rst = 1'b1;
      #1;
      chk("async_reset", 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
      #1;
      rst = 1'b0;
      apply(1'b1, 8'h10, 1'b0, 1'b0);
      apply(1'b1, 8'h20, 1'b0, 1'b0);
      apply(1'b1, 8'h30, 1'b0, 1'b0);
      apply(1'b1, 8'h40, 1'b0, 1'b0);
      chk("after_async", 32'h40302010, 1'b1, 3'd4, 1'b0, 1'b1);

      // Random traffic against the reference model
      apply(1'b0, 8'h00, 1'b1, 1'b0);
      model_reset();
      for (int i = 0; i < 300; i++) begin
         rx  = 1'($urandom_range(0, 1));
         d   = 8'($urandom_range(0, 255));
         clr = ($urandom_range(0, 31) == 0);
         ack = ($urandom_range(0, 2) == 0);
         model_step(rx, d, clr, ack);
         apply(rx, d, clr, ack);
         model_check($sformatf("rand%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/rx_word_assembler.md
Name: rx_word_assembler

Overview:
- Receive-side counterpart of the pipeline debug transmit path.
- Collects bytes delivered by the UART receiver, one per rx-done pulse, and packs them little-endian into WORD_WIDTH-bit words.
- Presents each completed word to the debug unit (instruction-memory loader / command decoder) with a valid/ack handshake.
- Byte 0 received lands in bits [7:0], matching the transmit side, which sends the LSB byte first.

Parameters:
- WORD_WIDTH, 32, width of assembled word; must be an integer multiple of RX_WIDTH.
- RX_WIDTH, 8, width of one received UART byte.
- Derived: BYTES_PER_WORD = WORD_WIDTH/RX_WIDTH.
- Derived: CNT_W = $clog2(BYTES_PER_WORD)+1.

Ports:
- i_clk  input  1  system clock; all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_done  input  1  one-cycle pulse from UART RX; i_rx_data valid in that cycle.
- i_rx_data  input  RX_WIDTH  received byte.
- i_clear  input  1  synchronous abort; discards partial or complete word.
- i_word_ack  input  1  consumer accepts o_word; meaningful only while o_word_valid=1.
- o_word  output  WORD_WIDTH  assembled word; stable while o_word_valid=1.
- o_word_valid  output  1  complete word available.
- o_byte_count  output  CNT_W  bytes held in current word, 0..BYTES_PER_WORD.
- o_overrun  output  1  sticky; a byte was dropped because a completed word was not yet acked.

Behaviour:
- Reset (async, i_reset=1): state=COLLECT, o_word=0, o_word_valid=0, o_byte_count=0, o_overrun=0. Reset mid-word discards the partial data; no output glitches back to prior values after release.
- Priority per edge: i_reset > i_clear > normal operation.
- i_clear=1: same values as reset, applied synchronously. Any coincident i_rx_done byte is dropped.
- States: COLLECT, FULL. All outputs registered.
- COLLECT, i_rx_done=1:
  - o_word[cnt*RX_WIDTH +: RX_WIDTH] <= i_rx_data, where cnt = o_byte_count before the edge.
  - o_byte_count increments.
  - If cnt == BYTES_PER_WORD-1: go to FULL and o_word_valid<=1 on the same edge.
  - Latency: o_word_valid is high in the cycle after the edge that samples the final byte.
- COLLECT, i_rx_done=0: hold all state.
- In COLLECT, unwritten byte lanes of o_word are don't-care for checking. Implementation zeroes o_word when a new word starts.
- FULL: o_word, o_byte_count=BYTES_PER_WORD and o_word_valid=1 hold until ack.
- FULL, i_word_ack=1, i_rx_done=0: o_word_valid<=0, o_byte_count<=0, o_word<=0, go to COLLECT.
- FULL, i_word_ack=1, i_rx_done=1 (simultaneous): word retired and the new byte stored as byte 0 of the next word. o_word<={0, i_rx_data}, o_byte_count<=1, o_word_valid<=0, COLLECT. No byte loss.
- FULL, i_word_ack=0, i_rx_done=1: byte dropped, o_word unchanged, o_overrun<=1.
- o_overrun is cleared only by reset or i_clear.
- i_word_ack while o_word_valid=0: ignored, no state change.
- i_rx_done pulses may arrive back-to-back (every cycle); each must be captured.
- o_byte_count never exceeds BYTES_PER_WORD and never wraps.
- No combinational path from inputs to outputs.

Test Plan:
- Reset, then rx_done with 0x78, 0x56, 0x34, 0x12 (gaps of 10 cycles) -> o_byte_count steps 1,2,3,4; o_word_valid=1 one cycle after the 4th pulse; o_word=0x12345678; o_overrun=0.
- Hold ack low, then send byte 0xAA -> o_word stays 0x12345678, o_overrun=1. Ack -> o_word_valid=0, o_byte_count=0, o_overrun still 1. Assert i_clear -> o_overrun=0.
- Word 0xDEADBEEF complete, then in one cycle i_word_ack=1 and rx_done=1 with 0x11 -> o_word_valid=0, o_byte_count=1, o_word[7:0]=0x11. Send 0x22, 0x33, 0x44 -> o_word=0x44332211 valid.
- Four rx_done pulses on consecutive cycles (0x01, 0x02, 0x03, 0x04) -> o_word=0x04030201, valid on cycle 5, nothing dropped.
- After 2 bytes (0xCD, 0xAB), pulse i_clear together with rx_done 0xFF -> o_byte_count=0, o_word_valid=0. Next four bytes 0x01..0x04 -> o_word=0x04030201.
- Assert i_reset asynchronously mid-word (after 3 bytes), between clock edges -> outputs go to 0 immediately. After release, four bytes 0x10, 0x20, 0x30, 0x40 -> o_word=0x40302010.
